// File: rtl/noc_vc_output_scheduler.sv
// noc_vc_output_scheduler
//
// Packet-atomic round-robin scheduler sharing one physical NoC output link
// between CHANNELS per-VC input FIFOs. Tracks downstream credits per VC,
// grants at most one VC per cycle and keeps the grant on one VC from the
// head flit to the tail flit. The granted flit and its VC number are
// registered onto the link.
//
// Ports
//   noc_clk        clock
//   noc_rst        synchronous active-high reset
//   in_valid       per-VC FIFO has a flit available
//   in_head        per-VC head-of-FIFO flit is a packet head
//   in_tail        per-VC head-of-FIFO flit is a packet tail
//   in_flit        per-VC flit payloads, VC v at [v*FLIT_WIDTH +: FLIT_WIDTH]
//   in_ready       pop strobe back to the FIFOs, one-hot or zero
//   credit_return  per-VC one-cycle pulse, downstream freed one slot
//   out_valid      registered link valid
//   out_flit       registered link flit
//   out_vc         registered VC id of out_flit
//   busy           a packet is currently locked onto the link

module noc_vc_output_scheduler #(
    parameter int CHANNELS   = 32,
    parameter int FLIT_WIDTH = 64,
    parameter int CREDITS    = 32,
    localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW  = $clog2(CREDITS + 1)
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst,
    input  logic [CHANNELS-1:0]            in_valid,
    input  logic [CHANNELS-1:0]            in_head,
    input  logic [CHANNELS-1:0]            in_tail,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic [CHANNELS-1:0]            credit_return,
    output logic                           out_valid,
    output logic [FLIT_WIDTH-1:0]          out_flit,
    output logic [VCW-1:0]                 out_vc,
    output logic                           busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state;
    logic [VCW-1:0]       rr_ptr;
    logic [VCW-1:0]       lock_vc;
    logic [CW-1:0]        credit   [CHANNELS];
    logic [FLIT_WIDTH-1:0] flit_arr [CHANNELS];

    logic [CHANNELS-1:0]  elig;
    logic [VCW-1:0]       cand;
    logic                 grant_vld_p0;
    logic [VCW-1:0]       grant_vc_p0;
    logic                 send_tail_p0;
    logic [VCW-1:0]       rr_wrap_p0;

    logic                 vld_p1;
    logic [FLIT_WIDTH-1:0] flit_p1;
    logic [VCW-1:0]       vc_p1;

    // ---- Stage p0: eligibility, arbitration and pop strobe ----

    always_comb begin
        for (int v = 0; v < CHANNELS; v++) begin
            flit_arr[v] = in_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
            elig[v]     = in_valid[v] && (credit[v] != '0);
        end
    end

    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_vc_p0  = '0;
        cand         = '0;
        if (!noc_rst) begin
            if (state == LOCKED) begin
                // Only the locked VC may continue; the head flag is not
                // required for body/tail flits.
                grant_vld_p0 = elig[lock_vc];
                grant_vc_p0  = lock_vc;
            end else begin
                // Scan from the highest offset down so the eligible VC
                // closest to rr_ptr is the last one written and wins.
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    cand = VCW'((int'(rr_ptr) + i) % CHANNELS);
                    if (elig[cand] && in_head[cand]) begin
                        grant_vld_p0 = 1'b1;
                        grant_vc_p0  = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant_vld_p0) begin
            in_ready[grant_vc_p0] = 1'b1;
        end
    end

    assign send_tail_p0 = in_tail[grant_vc_p0];
    assign rr_wrap_p0   = (grant_vc_p0 == VCW'(CHANNELS - 1)) ? '0 : grant_vc_p0 + VCW'(1);

    // Packet lock FSM and round-robin pointer.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_vc <= '0;
        end else if (grant_vld_p0) begin
            if (send_tail_p0) begin
                state  <= IDLE;
                rr_ptr <= rr_wrap_p0;
            end else if (state == IDLE) begin
                // A grant in IDLE is always a head, so head without tail
                // opens a multi-flit packet.
                state   <= LOCKED;
                lock_vc <= grant_vc_p0;
            end
        end
    end

    // Per-VC credit counters. A send and a return in the same cycle cancel.
    always_ff @(posedge noc_clk) begin
        for (int v = 0; v < CHANNELS; v++) begin
            if (noc_rst) begin
                credit[v] <= CW'(CREDITS);
            end else if (credit_return[v] && !in_ready[v]) begin
                if (credit[v] != CW'(CREDITS)) begin
                    credit[v] <= credit[v] + CW'(1);
                end
            end else if (in_ready[v] && !credit_return[v]) begin
                credit[v] <= credit[v] - CW'(1);
            end
        end
    end

    assign busy = (state == LOCKED);

    // ---- Stage p1: registered link output ----

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            vld_p1  <= 1'b0;
            flit_p1 <= '0;
            vc_p1   <= '0;
        end else begin
            vld_p1 <= grant_vld_p0;
            if (grant_vld_p0) begin
                flit_p1 <= flit_arr[grant_vc_p0];
                vc_p1   <= grant_vc_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_flit  = flit_p1;
    assign out_vc    = vc_p1;

    // Protocol checks on the surrounding logic.
    always_ff @(posedge noc_clk) begin
        if (!noc_rst) begin
            assert ($onehot0(in_ready));
            for (int v = 0; v < CHANNELS; v++) begin
                // Credit return beyond the downstream buffer depth.
                assert (!(credit_return[v] && !in_ready[v] && credit[v] == CW'(CREDITS)));
                // Body or tail flit offered while no packet is open.
                assert (!(state == IDLE && in_valid[v] && !in_head[v]));
            end
        end
    end

endmodule

// File: tb/tb_noc_vc_output_scheduler.sv
module tb_noc_vc_output_scheduler;

    localparam int CH    = 4;
    localparam int FW    = 16;
    localparam int CR    = 4;
    localparam int VCW   = 2;
    localparam int DEPTH = 64;

    logic              noc_clk = 1'b0;
    logic              noc_rst;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_head;
    logic [CH-1:0]     in_tail;
    logic [CH*FW-1:0]  in_flit;
    logic [CH-1:0]     in_ready;
    logic [CH-1:0]     credit_return;
    logic              out_valid;
    logic [FW-1:0]     out_flit;
    logic [VCW-1:0]    out_vc;
    logic              busy;

    noc_vc_output_scheduler #(
        .CHANNELS   (CH),
        .FLIT_WIDTH (FW),
        .CREDITS    (CR)
    ) dut (
        .noc_clk       (noc_clk),
        .noc_rst       (noc_rst),
        .in_valid      (in_valid),
        .in_head       (in_head),
        .in_tail       (in_tail),
        .in_flit       (in_flit),
        .in_ready      (in_ready),
        .credit_return (credit_return),
        .out_valid     (out_valid),
        .out_flit      (out_flit),
        .out_vc        (out_vc),
        .busy          (busy)
    );

    always #5 noc_clk = ~noc_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Per-VC FIFO contents: {head, tail, payload}
    logic [FW+1:0] mem [CH][DEPTH];
    int            rd  [CH];
    int            wr  [CH];
    logic [CH-1:0] hold;
    int            seq;

    // Reference model state
    int             m_cred [CH];
    int             m_lock;          // -1 when no packet is open
    int             m_rr;
    logic           m_ov;
    logic [FW-1:0]  m_flit;
    logic [VCW-1:0] m_vc;

    int cyc;
    int base;
    int log_vc[$];
    int log_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int v, input int len);
        for (int i = 0; i < len; i++) begin
            logic [FW-1:0] pl;
            pl = {v[3:0], seq[11:0]};
            seq++;
            mem[v][wr[v] % DEPTH] = {(i == 0), (i == len - 1), pl};
            wr[v]++;
        end
    endtask

    task automatic flush();
        for (int v = 0; v < CH; v++) begin
            rd[v] = 0;
            wr[v] = 0;
        end
        hold = '0;
        log_vc.delete();
        log_cyc.delete();
        base = cyc;
    endtask

    task automatic model_reset();
        for (int v = 0; v < CH; v++) m_cred[v] = CR;
        m_lock = -1;
        m_rr   = 0;
        m_ov   = 1'b0;
        m_flit = '0;
        m_vc   = '0;
    endtask

    task automatic drive(input logic [CH-1:0] ret);
        logic [FW+1:0] e;
        for (int v = 0; v < CH; v++) begin
            if (rd[v] != wr[v] && !hold[v]) begin
                e = mem[v][rd[v] % DEPTH];
                in_valid[v]         = 1'b1;
                in_head[v]          = e[FW+1];
                in_tail[v]          = e[FW];
                in_flit[v*FW +: FW] = e[FW-1:0];
            end else begin
                in_valid[v]         = 1'b0;
                in_head[v]          = 1'b0;
                in_tail[v]          = 1'b0;
                in_flit[v*FW +: FW] = '0;
            end
        end
        credit_return = ret;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic [CH-1:0] ret);
        int            g;
        int            v;
        logic [FW+1:0] e;
        logic [CH-1:0] exp_rdy;
        drive(ret);
        #1;
        check("busy", busy, m_lock >= 0);
        check("out_valid", out_valid, m_ov);
        check("out_flit", out_flit, m_flit);
        check("out_vc", out_vc, m_vc);
        if (out_valid) begin
            log_vc.push_back(int'(out_vc));
            log_cyc.push_back(cyc - base);
        end
        g = -1;
        if (m_lock >= 0) begin
            if (in_valid[m_lock] && m_cred[m_lock] > 0) g = m_lock;
        end else begin
            for (int i = 0; i < CH; i++) begin
                v = (m_rr + i) % CH;
                if (g < 0 && in_valid[v] && in_head[v] && m_cred[v] > 0) g = v;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", in_ready, exp_rdy);
        if (g >= 0) begin
            e = mem[g][rd[g] % DEPTH];
            rd[g]++;
            m_cred[g]--;
            m_ov   = 1'b1;
            m_flit = e[FW-1:0];
            m_vc   = VCW'(g);
            if (e[FW]) begin
                m_lock = -1;
                m_rr   = (g + 1) % CH;
            end else if (m_lock < 0) begin
                m_lock = g;
            end
        end else begin
            m_ov = 1'b0;
        end
        for (int k = 0; k < CH; k++) if (ret[k]) m_cred[k]++;
        @(posedge noc_clk);
        @(negedge noc_clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        noc_rst = 1'b1;
        repeat (n) begin
            drive('0);
            #1;
            check("rst_in_ready", in_ready, '0);
            @(posedge noc_clk);
            @(negedge noc_clk);
            cyc++;
        end
        noc_rst = 1'b0;
        model_reset();
    endtask

    task automatic check_obs(input string tag, input int i, input int vc, input int rel);
        check({tag, "_vc"},  (i < log_vc.size())  ? log_vc[i]  : -1, vc);
        check({tag, "_cyc"}, (i < log_cyc.size()) ? log_cyc[i] : -1, rel);
    endtask

    function automatic logic [CH-1:0] rand_ret(input int pct);
        logic [CH-1:0] r;
        r = '0;
        for (int v = 0; v < CH; v++)
            if (m_cred[v] < CR && $urandom_range(0, 99) < pct) r[v] = 1'b1;
        return r;
    endfunction

    initial begin
        cyc = 0;
        seq = 0;
        noc_rst = 1'b1;
        in_valid = '0;
        in_head = '0;
        in_tail = '0;
        in_flit = '0;
        credit_return = '0;
        flush();
        model_reset();
        @(negedge noc_clk);
        do_reset(2);

        // Round-robin fairness across four single-flit streams
        flush();
        for (int r = 0; r < 3; r++)
            for (int v = 0; v < CH; v++) push_pkt(v, 1);
        repeat (13) step(rand_ret(100));
        check("rr_count", log_vc.size(), 12);
        for (int i = 0; i < 12; i++) check_obs("rr", i, i % 4, i + 1);

        // Packet atomicity with a stalled body flit
        do_reset(1);
        flush();
        push_pkt(1, 3);
        push_pkt(2, 1);
        step('0);
        hold = 4'b0010;
        step('0);
        check("atom_busy_gap", busy, 1'b1);
        step('0);
        hold = '0;
        repeat (4) step('0);
        check("atom_count", log_vc.size(), 4);
        check_obs("atom_h", 0, 1, 1);
        check_obs("atom_b", 1, 1, 4);
        check_obs("atom_t", 2, 1, 5);
        check_obs("atom_vc2", 3, 2, 6);

        // Credit exhaustion, then one return gives one send
        do_reset(1);
        flush();
        for (int i = 0; i < 6; i++) push_pkt(0, 1);
        repeat (6) step('0);
        check("exh_count", log_vc.size(), 4);
        check("exh_rdy", in_ready[0], 1'b0);
        step(4'b0001);
        repeat (3) step('0);
        check("exh_count2", log_vc.size(), 5);
        check_obs("exh_extra", 4, 0, 8);

        // Send and return in the same cycle on VC3
        do_reset(1);
        flush();
        for (int i = 0; i < 5; i++) push_pkt(3, 1);
        repeat (3) step('0);
        step(4'b1000);
        repeat (3) step('0);
        check("simul_count", log_vc.size(), 5);
        check_obs("simul_last", 4, 3, 5);

        // Locked VC starved of credits blocks other VCs
        do_reset(1);
        flush();
        push_pkt(2, 5);
        push_pkt(0, 1);
        hold = 4'b0001;
        step('0);
        hold = '0;
        repeat (5) step('0);
        check("starve_busy", busy, 1'b1);
        step(4'b0100);
        repeat (3) step('0);
        check("starve_count", log_vc.size(), 6);
        check_obs("starve_b3", 3, 2, 4);
        check_obs("starve_tail", 4, 2, 8);
        check_obs("starve_vc0", 5, 0, 9);

        // Reset while locked on VC1 (rr_ptr is 1 from the previous packet)
        flush();
        push_pkt(1, 5);
        repeat (3) step('0);
        check("mid_busy_pre", busy, 1'b1);
        do_reset(1);
        flush();
        check("mid_busy", busy, 1'b0);
        check("mid_ov", out_valid, 1'b0);
        push_pkt(0, 1);
        for (int i = 0; i < 5; i++) push_pkt(1, 1);
        repeat (8) step('0);
        check("mid_count", log_vc.size(), 5);
        check_obs("mid_first", 0, 0, 1);
        check_obs("mid_vc1", 4, 1, 5);

        // Randomized traffic against the reference model
        do_reset(1);
        flush();
        for (int n = 0; n < 3000; n++) begin
            int v;
            v = $urandom_range(0, CH - 1);
            if ($urandom_range(0, 1) == 1 && (wr[v] - rd[v]) < DEPTH - 8)
                push_pkt(v, $urandom_range(1, 4));
            hold = CH'($urandom & $urandom);
            step(rand_ret(40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_vc_output_scheduler.md
# noc_vc_output_scheduler

Packet-atomic round-robin scheduler that shares one physical NoC output link between the `CHANNELS` per-VC input FIFOs of a router port. It sits between the per-VC input buffers and the link register. It tracks downstream buffer credits per VC, grants one VC per cycle, and holds a grant from head flit to tail flit. The chosen flit is driven onto a registered output together with its VC number.

## Interface

**Parameters**
- `CHANNELS`, 32: number of virtual channels; must be ≥ 2.
- `FLIT_WIDTH`, 64: flit payload width in bits.
- `CREDITS`, 32: downstream buffer depth per VC, which is also the initial credit count.

**Ports** (clock and reset first)
- `noc_clk`, in, 1: the single clock.
- `noc_rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, CHANNELS: per-VC FIFO has a flit available.
- `in_head`, in, CHANNELS: the flit at the head of that VC's FIFO is a packet head.
- `in_tail`, in, CHANNELS: the flit at the head of that VC's FIFO is a packet tail. Head and tail both set means a single-flit packet.
- `in_flit`, in, CHANNELS×FLIT_WIDTH: per-VC flit payload.
- `in_ready`, out, CHANNELS: pop strobe; one-hot or zero.
- `credit_return`, in, CHANNELS: downstream freed one slot on VC v; one-cycle pulse per slot.
- `out_valid`, out, 1: registered link valid.
- `out_flit`, out, FLIT_WIDTH: registered link flit.
- `out_vc`, out, VCW = max(1, $clog2(CHANNELS)): registered VC id of `out_flit`.
- `busy`, out, 1: a packet is currently locked.

## Operation

**Credits**
- One counter per VC, width $clog2(CREDITS+1), reset to `CREDITS`.
- A send on VC v decrements `credit[v]` by 1. `credit_return[v]` increments it by 1. Both in the same cycle leave it unchanged.
- A return that would exceed `CREDITS` is a protocol error. The counter saturates at `CREDITS` and a simulation assertion fires.

**Eligibility**
- `elig[v] = in_valid[v] && credit[v] != 0`.
- In IDLE, `in_head[v]` is also required. A non-head flit seen while idle is ignored and flagged by an assertion.

**FSM**
- States are IDLE and LOCKED, with a lock register `lock_vc`.
- IDLE:
  - Grant the first eligible v, scanning round-robin from `rr_ptr` upward and wrapping modulo `CHANNELS`.
  - A granted flit with head=1 and tail=0 → go to LOCKED with `lock_vc = v`.
  - A granted single-flit packet stays in IDLE.
- LOCKED:
  - Only `lock_vc` may be granted, and only when `elig[lock_vc]` holds, ignoring the head requirement.
  - Other VCs wait even if `lock_vc` is starved of flits or credits. Packets are never interleaved on the link.
  - Sending the tail flit → IDLE.
- Round-robin pointer: when a packet's tail is sent on VC v, `rr_ptr = (v+1) mod CHANNELS`. Otherwise it holds.
- A send occurs when `in_valid[v] && in_ready[v]`. `in_ready` is combinational from the current state, credits and `in_valid`. It is at most one-hot and never asserted on a VC with zero credits.
- `busy = (state == LOCKED)`.

## Timing

- Reset values: `state` = IDLE, `rr_ptr` = 0, `lock_vc` = 0, all credits = `CREDITS`, `out_valid` = 0, `out_flit` = 0, `out_vc` = 0, `busy` = 0. `in_ready` is 0 during reset.
- Latency: a flit popped in cycle t appears on `out_flit`/`out_vc` with `out_valid` = 1 in cycle t+1.
  - `out_valid` is 0 in any cycle following a cycle with no send.
  - `out_flit` and `out_vc` hold their last value when `out_valid` = 0.
- Throughput: one flit per cycle, including back-to-back packets from different VCs. A tail in cycle t allows a new head from another VC in cycle t+1.
- The link has no backpressure; flow control is entirely by credits.
  - With `CREDITS` = N and no returns, exactly N flits per VC are sent.
  - A return in cycle t makes a send possible in cycle t+1.
- Reset asserted mid-packet: state, lock and credits are reinitialised on the next edge. `out_valid` is 0 the cycle after reset is sampled.

## Test plan

All scenarios use `CHANNELS` = 4 and `CREDITS` = 4.

1. **Round-robin fairness.** VCs 0–3 each hold three single-flit packets and credits are returned each cycle. Required `out_vc` sequence: 0,1,2,3,0,1,2,3,0,1,2,3 with no idle cycles.
2. **Packet atomicity.** VC1 sends a 3-flit packet H,B,T while VC2 holds a head; VC1's body is delayed 2 cycles. Required: `out_vc` = 1,1,1 with 2 gap cycles (`out_valid` = 0) before the body, VC2 not granted until the cycle after VC1's tail, and `busy` = 1 from the head until the tail send.
3. **Credit exhaustion.** VC0 has a continuous stream of 6 single-flit packets and no returns. Required: exactly 4 sends, then `in_ready[0]` = 0. Pulsing `credit_return[0]` once in cycle t gives exactly one more send in cycle t+1.
4. **Simultaneous send and return.** VC3 at credit 1 sends while `credit_return[3]` pulses in the same cycle. Required: credit stays 1 and the next flit is sent in the following cycle.
5. **Lock starvation on credits.** VC2 is locked mid-packet with credit 0 while VC0 is eligible. Required: VC0 is not granted. After one return on VC2, VC2's next flit is sent.
6. **Reset mid-packet.** `noc_rst` is asserted for one cycle while LOCKED on VC1 with credit 1. Required: the next cycle shows `busy` = 0, `out_valid` = 0 and credits = 4. A new head on VC0 is granted first because `rr_ptr` = 0.
